// File: rtl/core_pkg.sv
// Shared constants and types for the interrupt sequencer.
package core_pkg;

    // Machine-mode return instruction encoding.
    localparam logic [31:0] MRET_INSN = 32'h3020_0073;

    // Default handler entry point. It must be word-aligned.
    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0100;

    // Sequencer states: normal execution, or servicing the interrupt.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } irq_state_e;

endpackage : core_pkg

// File: rtl/btn_debouncer.sv
// Push-button conditioner.
// A 2-flop synchronizer feeds a stability counter. rise is a one-cycle pulse that is
// high in the cycle before btn1 goes 0->1.
module btn_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic btn1,
    output logic rise
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s2_q;
    logic            btn1_q, btn1_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cnt_done;

    assign cnt_done = (cnt_q == CntLast);

    // Next-state logic. The counter only runs while the synchronized input
    // disagrees with the accepted level. It clears before it can wrap.
    always_comb begin
        btn1_d = btn1_q;
        cnt_d  = '0;
        if (s2_q != btn1_q) begin
            if (cnt_done) begin
                btn1_d = s2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Synchronizer, counter and debounced-level registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            btn1_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= btn;
            s2_q   <= s1_q;
            btn1_q <= btn1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign btn1 = btn1_q;
    // High in the cycle whose closing edge raises btn1.
    assign rise = s2_q & ~btn1_q & cnt_done;

endmodule : btn_debouncer

// File: rtl/irq_sequencer.sv
// Single-source interrupt sequencer.
// It chooses what the PC register loads each cycle: the datapath next-PC, the handler
// vector, or the saved EPC. It also holds the EPC and the in-handler status.
module irq_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR    = DEFAULT_HANDLER_ADDR,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic        irq_en,
    input  logic [31:0] pc,
    input  logic [31:0] next,
    input  logic [31:0] instruction,
    output logic [31:0] pc_next,
    output logic [31:0] epc,
    output logic        iled,
    output logic        btn1,
    output logic        irq_taken
);

    irq_state_e  state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] epc_q, epc_d;
    logic        btn_rise;
    logic        is_mret;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk  (clk),
        .reset(reset),
        .btn  (btn),
        .btn1 (btn1),
        .rise (btn_rise)
    );

    assign is_mret = (instruction == MRET_INSN);

    // Next-state and PC-select logic. The instruction in the entry cycle still
    // completes, so the EPC captures its successor (next).
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        epc_d     = epc_q;
        pc_next   = next;
        irq_taken = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (pend_q && irq_en) begin
                    pc_next   = HANDLER_ADDR;
                    irq_taken = 1'b1;
                    epc_d     = next;
                    pend_d    = 1'b0;
                    state_d   = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                // No nesting. A pending request waits until we are back in RUN.
                if (is_mret) begin
                    pc_next = epc_q;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // A new edge that coincides with entry must not be lost, so set wins over clear.
        if (btn_rise) begin
            pend_d = 1'b1;
        end
    end

    // State, pending flag and EPC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            epc_q   <= epc_d;
        end
    end

    assign epc  = epc_q;
    assign iled = (state_q == ST_HANDLER);

    // The PC is only observed to confirm that fetches stay word-aligned.
    a_pc_aligned: assert property (@(posedge clk) disable iff (reset)
        (pc & 32'h0000_0003) == 32'h0);

endmodule : irq_sequencer

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer. DEBOUNCE_CYCLES = 16, so btn1 follows btn 18 edges later.
module tb_irq_sequencer;

    localparam logic [31:0] Mret    = 32'h3020_0073;
    localparam logic [31:0] Handler = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn;
    logic        irq_en;
    logic [31:0] pc;
    logic [31:0] next;
    logic [31:0] instruction;
    logic [31:0] pc_next;
    logic [31:0] epc;
    logic        iled;
    logic        btn1;
    logic        irq_taken;

    int n_checks = 0;
    int n_fail   = 0;

    irq_sequencer #(
        .HANDLER_ADDR   (Handler),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .irq_en     (irq_en),
        .pc         (pc),
        .next       (next),
        .instruction(instruction),
        .pc_next    (pc_next),
        .epc        (epc),
        .iled       (iled),
        .btn1       (btn1),
        .irq_taken  (irq_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges. Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset       = 1'b1;
        btn         = 1'b0;
        irq_en      = 1'b0;
        pc          = 32'h0;
        next        = 32'h10;
        instruction = 32'h0;
        tick(2);
        check("rst_pc_next", pc_next, 32'h10);
        check("rst_epc", epc, 32'h0);
        check("rst_iled", {31'b0, iled}, 32'h0);
        check("rst_btn1", {31'b0, btn1}, 32'h0);
        check("rst_irq_taken", {31'b0, irq_taken}, 32'h0);

        // Press, then reset again partway through the count.
        reset = 1'b0;
        btn   = 1'b1;
        tick(8);
        reset = 1'b1;
        #1;
        check("midrst_btn1", {31'b0, btn1}, 32'h0);
        check("midrst_iled", {31'b0, iled}, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(17);
        check("btn1_edge17", {31'b0, btn1}, 32'h0);
        tick(1);
        check("btn1_edge18", {31'b0, btn1}, 32'h1);

        // irq_en low: the request stays pending and is not serviced.
        for (int i = 0; i < 50; i++) begin
            next = 32'h1000 + 32'(i * 4);
            #1;
            check("dis_irq_taken", {31'b0, irq_taken}, 32'h0);
            check("dis_pc_next", pc_next, 32'h1000 + 32'(i * 4));
            tick(1);
        end
        irq_en = 1'b1;
        next   = 32'h40;
        #1;
        check("en_irq_taken", {31'b0, irq_taken}, 32'h1);
        check("en_pc_next", pc_next, Handler);
        tick(1);
        check("en_epc", epc, 32'h40);
        check("en_iled", {31'b0, iled}, 32'h1);
        check("en_taken_pulse", {31'b0, irq_taken}, 32'h0);

        // In the handler: ordinary instruction, then MRET.
        next = 32'h104;
        #1;
        check("hdl_pc_next", pc_next, 32'h104);
        instruction = Mret;
        next        = 32'h108;
        #1;
        check("mret_pc_next", pc_next, 32'h40);
        check("mret_irq_taken", {31'b0, irq_taken}, 32'h0);
        tick(1);
        check("mret_iled", {31'b0, iled}, 32'h0);
        // An MRET seen in RUN has no effect.
        next = 32'h44;
        #1;
        check("run_mret_ignored", pc_next, 32'h44);
        instruction = 32'h0;

        // Release the button.
        btn = 1'b0;
        tick(18);
        check("release_btn1", {31'b0, btn1}, 32'h0);

        // A 10-cycle glitch is shorter than the debounce window.
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next = 32'h500 + 32'(i * 4);
            #1;
            check("glitch_irq_taken", {31'b0, irq_taken}, 32'h0);
            check("glitch_pc_next", pc_next, 32'h500 + 32'(i * 4));
            tick(1);
        end
        btn = 1'b0;
        tick(20);
        check("glitch_btn1", {31'b0, btn1}, 32'h0);
        check("glitch_iled", {31'b0, iled}, 32'h0);

        // Clean press with irq_en high. Redirect happens in the cycle after btn1 rises.
        btn  = 1'b1;
        next = 32'h600;
        tick(17);
        check("press_taken_early", {31'b0, irq_taken}, 32'h0);
        tick(1);
        next = 32'h200;
        #1;
        check("press_btn1", {31'b0, btn1}, 32'h1);
        check("press_irq_taken", {31'b0, irq_taken}, 32'h1);
        check("press_pc_next", pc_next, Handler);
        tick(1);
        check("press_iled", {31'b0, iled}, 32'h1);
        check("press_epc", epc, 32'h200);

        // Second press while in the handler: it becomes pending but is not serviced.
        btn = 1'b0;
        tick(18);
        check("second_release", {31'b0, btn1}, 32'h0);
        btn = 1'b1;
        tick(18);
        check("second_btn1", {31'b0, btn1}, 32'h1);
        next = 32'h108;
        #1;
        check("nonest_taken", {31'b0, irq_taken}, 32'h0);
        check("nonest_pc_next", pc_next, 32'h108);
        instruction = Mret;
        next        = 32'h10c;
        #1;
        check("ret2_pc_next", pc_next, 32'h200);
        tick(1);
        // One RUN cycle at the EPC, then re-entry from it.
        instruction = 32'h0;
        next        = 32'h204;
        #1;
        check("reentry_iled", {31'b0, iled}, 32'h0);
        check("reentry_taken", {31'b0, irq_taken}, 32'h1);
        check("reentry_pc_next", pc_next, Handler);
        tick(1);
        check("reentry_epc", epc, 32'h204);
        check("reentry_iled_hi", {31'b0, iled}, 32'h1);

        // Reset inside the handler drops the handler state and the EPC.
        reset = 1'b1;
        #1;
        check("hrst_iled", {31'b0, iled}, 32'h0);
        check("hrst_epc", epc, 32'h0);
        tick(1);
        reset = 1'b0;
        next  = 32'h300;
        #1;
        check("hrst_irq_taken", {31'b0, irq_taken}, 32'h0);
        check("hrst_pc_next", pc_next, 32'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_irq_sequencer
